// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset core: opcode/funct encodings,
// fetch state encoding and the program counter width.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage: sequential PC+4,
// branch target and pseudo-direct jump target (jump wins over branch).
module fetch_next_pc
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] instr_pcplus4,
    input  logic [25:0]     jump_index,
    input  logic            is_jump,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset,
    output logic [PC_W-1:0] seq_pc,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;

    // All sums wrap modulo 2^32; the shift drops the offset's top two bits.
    assign seq_pc        = pc + 32'd4;
    assign branch_target = instr_pcplus4 + (branch_offset << 2);
    assign jump_target   = {instr_pcplus4[31:28], jump_index, 2'b00};

    always_comb begin
        next_pc = instr_pcplus4;
        if (is_jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake and instruction register.
// Define FETCH_JUMP_EN to let a held j instruction redirect the PC.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [31:0]     branch_offset,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [5:0]      opcode,
    output logic [5:0]      funct,
    output logic [PC_W-1:0] instr_pcplus4
);

    localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};

    fetch_state_t    state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [31:0]     instr_reg;
    logic [PC_W-1:0] pcplus4_reg;
    logic            valid_reg;
    logic            req_reg;
    logic            is_jump;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] next_pc;

`ifdef FETCH_JUMP_EN
    assign is_jump = (instr_reg[31:26] == OP_J);
`else
    assign is_jump = 1'b0;
`endif

    fetch_next_pc u_next_pc (
        .pc            (pc_reg),
        .instr_pcplus4 (pcplus4_reg),
        .jump_index    (instr_reg[25:0]),
        .is_jump       (is_jump),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .seq_pc        (seq_pc),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC_ALIGNED;
            req_reg     <= 1'b0;
            instr_reg   <= 32'd0;
            valid_reg   <= 1'b0;
            pcplus4_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_FETCH;
                    req_reg   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_reg   <= imem_rdata;
                        pcplus4_reg <= seq_pc;
                        valid_reg   <= 1'b1;
                        req_reg     <= 1'b0;
                        state_reg   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Redirect inputs only matter on the consuming edge.
                    if (!stall) begin
                        pc_reg    <= next_pc;
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = req_reg;
    assign imem_addr     = pc_reg;
    assign instr         = instr_reg;
    assign instr_valid   = valid_reg;
    assign instr_pcplus4 = pcplus4_reg;
    assign opcode        = instr_reg[31:26];
    assign funct         = instr_reg[5:0];

endmodule
